// File: rtl/rf_write_arbiter_pkg.sv
// rf_pkg: shared constants and types for the register-file write arbiter.
//   REG_AW / REG_DW : default register address / data widths
//   REG_ZERO        : the hardwired-zero register address
//   wb_req_t        : one writeback request {addr, data} at default widths
package rf_pkg;
    localparam int          REG_AW   = 5;
    localparam int          REG_DW   = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester handshake bus plus the register-file write
// port it is funnelled onto.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_addr/req_data   : flattened per-requester address / data slices
//   wr/rd/write_data    : register-file write port
//   wr_id               : requester index of the current write beat
// master = requester/register-file side, slave = the arbiter.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               wr;
    logic [AW-1:0]      rd;
    logic [DW-1:0]      write_data;
    logic [IDW-1:0]     wr_id;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr, rd, write_data, wr_id
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr, rd, write_data, wr_id
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority picker.
//   req  : request vector
//   ptr  : highest-priority index this cycle (must be < NREQ)
//   en   : when low, no grant is produced
//   gnt  : one-hot grant
//   idx  : encoded index of the grant (0 when no grant)
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    // Walk offsets from the farthest to the nearest so the request closest
    // to ptr (in wrap-around order) is the last one written and wins.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (en && req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between
// NREQ writeback requesters with round-robin arbitration. The accepted
// request is registered and appears on the write port one cycle later.
// Writes to register 0 are accepted but never raise wr.
//   clk, rst  : clock, synchronous active-high reset
//   hold      : freezes arbitration (no acceptance while high)
//   wr_count  : saturating count of wr pulses since reset
//   bus       : requester handshake + register-file write port (slave)
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW,
    parameter int IDW  = 1,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    output logic [CW-1:0]        wr_count,
    rf_write_arbiter_if.slave    bus
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            xfer;
    req_t            sel;

    logic            wr_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   data_q;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   cnt_q;

    // Gating enable with rst keeps req_ready low during reset without any
    // dependence on the request payload.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .en  (!hold && !rst),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // A grant is only ever issued to a valid requester, so any grant is a
    // completed transfer this cycle.
    assign xfer     = |gnt;
    assign sel.addr = bus.req_addr[int'(gnt_idx)*AW +: AW];
    assign sel.data = bus.req_data[int'(gnt_idx)*DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            wr_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            id_q   <= '0;
            cnt_q  <= '0;
        end else begin
            // Register-0 writes complete the handshake but never reach the RF.
            wr_q <= xfer && (sel.addr != '0);
            if (xfer) begin
                rd_q   <= sel.addr;
                data_q <= sel.data;
                id_q   <= gnt_idx;
                ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (xfer && (sel.addr != '0) && (cnt_q != {CW{1'b1}}))
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.wr         = wr_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = data_q;
    assign bus.wr_id      = id_q;
    assign wr_count       = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with two requesters and a 3-bit
// counter so saturation is reachable in a few writes.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int IDW  = 1;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic [CW-1:0] wr_count;

    int n_total = 0;
    int n_pass  = 0;

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .wr_count (wr_count),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        #1;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic [4:0] r,
                           input logic [31:0] d, input logic id, input logic [2:0] c);
        chk({tag, ".wr"}, 64'(bus.wr), 64'(w));
        chk({tag, ".rd"}, 64'(bus.rd), 64'(r));
        chk({tag, ".data"}, 64'(bus.write_data), 64'(d));
        chk({tag, ".id"}, 64'(bus.wr_id), 64'(id));
        chk({tag, ".cnt"}, 64'(wr_count), 64'(c));
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        set_req(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        tick();
        tick();
        // reset state; ready forced low even with valid requests
        chk("rst.ready", 64'(bus.req_ready), 64'h0);
        chk_out("rst", 1'b0, 5'd0, 32'h0, 1'b0, 3'd0);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rst = 1'b0;

        // single requester
        set_req(2'b01, 5'd5, 32'h7, 5'd0, 32'h0);
        chk("single.ready", 64'(bus.req_ready), 64'h1);
        tick();
        set_req(2'b00, 5'd5, 32'h7, 5'd0, 32'h0);
        chk_out("single.beat", 1'b1, 5'd5, 32'h7, 1'b0, 3'd1);
        tick();
        chk_out("single.idle", 1'b0, 5'd5, 32'h7, 1'b0, 3'd1);

        // return ptr to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.cnt", 64'(wr_count), 64'h0);

        // contention: grants alternate 0,1,0,1
        set_req(2'b11, 5'd1, 32'hA, 5'd2, 32'hB);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont%0d.ready", i), 64'(bus.req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            chk_out($sformatf("cont%0d", i), 1'b1, (i % 2 == 0) ? 5'd1 : 5'd2,
                    (i % 2 == 0) ? 32'hA : 32'hB, (i % 2 == 0) ? 1'b0 : 1'b1, 3'(i + 1));
        end

        // register 0: accepted, no write, count unchanged, ptr -> 0
        set_req(2'b10, 5'd1, 32'hA, 5'd0, 32'hFFFF_FFFF);
        chk("r0.ready", 64'(bus.req_ready), 64'h2);
        tick();
        chk_out("r0.beat", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 3'd4);

        // hold for 3 cycles with both valid
        hold = 1'b1;
        set_req(2'b11, 5'd1, 32'hA, 5'd2, 32'hB);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d.ready", i), 64'(bus.req_ready), 64'h0);
            tick();
            chk($sformatf("hold%0d.wr", i), 64'(bus.wr), 64'h0);
        end
        hold = 1'b0;
        #1;
        chk("unhold.ready", 64'(bus.req_ready), 64'h1);
        tick();
        chk_out("unhold.beat", 1'b1, 5'd1, 32'hA, 1'b0, 3'd5);

        // same address, ptr=1: requester 1 first, then 0
        set_req(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
        chk("same.ready1", 64'(bus.req_ready), 64'h2);
        tick();
        chk_out("same.beat1", 1'b1, 5'd3, 32'h22, 1'b1, 3'd6);
        set_req(2'b01, 5'd3, 32'h11, 5'd3, 32'h22);
        chk("same.ready2", 64'(bus.req_ready), 64'h1);
        tick();
        chk_out("same.beat2", 1'b1, 5'd3, 32'h11, 1'b0, 3'd7);

        // counter saturates at 7
        set_req(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        tick();
        chk_out("sat", 1'b1, 5'd6, 32'h66, 1'b0, 3'd7);

        // reset mid-stream: in-flight write cancelled
        set_req(2'b01, 5'd4, 32'h55, 5'd0, 32'h0);
        tick();
        chk("mid.wr_before", 64'(bus.wr), 64'h1);
        rst = 1'b1;
        set_req(2'b11, 5'd4, 32'h55, 5'd2, 32'hB);
        chk("mid.ready_rst", 64'(bus.req_ready), 64'h0);
        tick();
        chk("mid.wr_after", 64'(bus.wr), 64'h0);
        chk("mid.cnt_after", 64'(wr_count), 64'h0);
        chk("mid.ready_rst2", 64'(bus.req_ready), 64'h0);
        rst = 1'b0;
        #1;
        chk("mid.ready_ptr0", 64'(bus.req_ready), 64'h1);
        tick();
        chk_out("mid.beat", 1'b1, 5'd4, 32'h55, 1'b0, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (wr, rd, write_data) between NREQ writeback requesters, e.g. the ALU result path and the load-return path.
- Per-requester valid/ready handshake with round-robin arbitration; the winning request is registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and reg_file.
- Discards writes to register 0 while still completing the handshake.

Parameters:
- NREQ, 2, number of writeback requesters (2..4)
- AW, 5, register address width
- DW, 32, data width
- IDW, 1, grant index width (must equal clog2(NREQ), minimum 1)
- CW, 16, width of the saturating write counter

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request i holds a write
- req_ready  out  NREQ  request i is accepted this cycle
- req_addr  in  NREQ*AW  destination register of requester i, in slice [i*AW +: AW]
- req_data  in  NREQ*DW  write data of requester i, in slice [i*DW +: DW]
- hold  in  1  freezes arbitration; no request accepted while high
- wr  out  1  register-file write enable
- rd  out  AW  register-file write address
- write_data  out  DW  register-file write data
- wr_id  out  IDW  requester index of the current wr beat
- wr_count  out  CW  number of wr pulses since reset, saturating

Behaviour:
- Reset (rst high at a clk edge):
  - wr=0, rd=0, write_data=0, wr_id=0, wr_count=0.
  - Round-robin pointer ptr=0.
  - req_ready is forced to all zeros while rst is high.
- Arbitration (combinational, each cycle):
  - When hold=0, the winner is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - req_ready is one-hot on the winner and zero for all others.
  - When hold=1 or no request is valid, req_ready is all zeros.
  - req_ready never depends on req_data or req_addr.
- Acceptance:
  - A transfer occurs on a clk edge where req_valid[i] and req_ready[i] are both 1.
  - A requester must hold valid, addr and data stable until it is accepted.
  - Losing requesters simply wait; there is no drop and no reordering within a requester.
- Pointer update:
  - On a transfer by requester i, ptr becomes (i+1) mod NREQ.
  - Otherwise ptr is unchanged, including when hold=1.
- Output stage, one register, latency exactly 1 cycle:
  - On a transfer, rd, write_data and wr_id load the winner's values on the next edge.
  - wr = 1 only when the accepted address is nonzero.
  - Cycles with no transfer give wr=0; rd, write_data and wr_id keep their last values.
  - The register file always accepts, so throughput is 1 write per cycle with no internal queue.
- Register 0:
  - A request with addr=0 is accepted (ready pulses) and advances ptr.
  - It produces wr=0 and does not increment wr_count.
- wr_count:
  - Increments by 1 on every cycle in which wr is being registered as 1.
  - Saturates at 2^CW-1 and never wraps.
- Simultaneous same-address requests: only the winner writes that cycle; the loser writes later, so the last write wins in grant order.
- hold asserted with valid requests pending: no grants; the output register goes to wr=0 on the next edge.
- Reset mid-operation: an in-flight registered write is cancelled (wr=0 next cycle); pending requests stay un-accepted.

Decomposition:
- Shared package rf_pkg:
  - constants REG_AW=5, REG_DW=32, REG_ZERO=5'd0
  - typedef for a writeback request {addr, data}
- One natural sub-module, rr_arbiter:
  - Generic NREQ round-robin priority picker.
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant and encoded index.
  - Purely combinational; ptr storage stays in the parent.

Test Plan:
- Single requester: rst 2 cycles, then req0 valid with addr=5, data=0x0000_0007 for one cycle → req_ready[0]=1 that cycle; next cycle wr=1, rd=5, write_data=7, wr_id=0; wr_count=1 by the following cycle.
- Contention: both requesters valid continuously (req0 addr=1 data=0xA, req1 addr=2 data=0xB), ptr=0 after reset → grants alternate 0,1,0,1; wr beats rd=1,2,1,2 with no idle cycles.
- Register 0 drop: req1 valid with addr=0, data=0xFFFF_FFFF → req_ready[1]=1 and ptr becomes 0; next cycle wr=0, wr_count unchanged.
- Hold: both requesters valid, hold=1 for 3 cycles → req_ready=00 and wr=0 throughout; after hold falls, the first grant goes to requester ptr.
- Same address: req0 addr=3 data=0x11 and req1 addr=3 data=0x22 together, ptr=1 → beat 1 writes 0x22 (wr_id=1), beat 2 writes 0x11 (wr_id=0).
- Reset mid-stream: rst asserted the cycle after a transfer → wr=0, wr_count=0, ptr=0 next cycle; req_ready stays 0 while rst is high.
